// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART transmit/receive paths:
//               parity mode constants, transmitter FSM state encoding and
//               a parity helper function.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } tx_state_t;

    // Parity bit for the given mode. Data narrower than 9 bits is passed
    // zero-extended, which leaves the XOR reduction unchanged.
    function automatic logic calc_parity(input int mode, input logic [8:0] data);
        logic bit_val;
        bit_val = 1'b0;
        if (mode == PAR_ODD) begin
            bit_val = ~^data;
        end else if (mode == PAR_EVEN) begin
            bit_val = ^data;
        end
        return bit_val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_if
// Description : Writer-side bus of the UART transmitter: write strobe and
//               data, FIFO status and the sticky overflow flag with its clear.
//               master = the writer, slave = the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
);
    logic                          wr_en;
    logic [DATA_W-1:0]             wr_data;
    logic                          full;
    logic                          empty;
    logic [$clog2(FIFO_DEPTH):0]   level;
    logic                          ovf_clr;
    logic                          overflow;

    modport master (
        output wr_en, wr_data, ovf_clr,
        input  full, empty, level, overflow
    );

    modport slave (
        input  wr_en, wr_data, ovf_clr,
        output full, empty, level, overflow
    );
endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock show-ahead FIFO. rd_data always presents the
//               head entry; rd_en pops it. Full/empty come from the
//               registered occupancy, so a pop never frees space for a write
//               in the same clk.
// Ports       : clk, rst_ff1 (async, active-high)
//               wr_en, wr_data        - push side
//               rd_en, rd_data        - pop side
//               full, empty, level    - status
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  wire logic                        clk,
    input  wire logic                        rst_ff1,
    input  wire logic                        wr_en,
    input  wire logic [DATA_W-1:0]           wr_data,
    input  wire logic                        rd_en,
    output logic      [DATA_W-1:0]           rd_data,
    output logic                             full,
    output logic                             empty,
    output logic      [$clog2(FIFO_DEPTH):0] level
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              w_push;
    logic              w_pop;

    assign full    = (r_level == LVL_W'(FIFO_DEPTH));
    assign empty   = (r_level == '0);
    assign level   = r_level;
    assign rd_data = r_mem[r_rd_ptr];

    assign w_push = wr_en & ~full;
    assign w_pop  = rd_en & ~empty;

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst_ff1) begin
        if (rst_ff1) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : UART transmitter with input FIFO. Frames are start bit,
//               DATA_W data bits LSB first, optional parity, STOP_BITS stop
//               bits. Bit timing comes from the one-clk baud_en tick; the
//               next queued word starts directly after the last stop bit.
// Ports       : clk, rst_ff1 (async, active-high)
//               baud_en   - bit-period boundary tick
//               wr_if     - writer bus (wr_en, wr_data, full, empty, level,
//                           ovf_clr, overflow)
//               ser_out   - serial line, idle high
//               tx_busy   - a frame is on the line
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_ff1,
    input  wire logic       baud_en,
    uart_tx_fifo_if.slave   wr_if,
    output logic            ser_out,
    output logic            tx_busy
);

    localparam int CNT_W = $clog2(DATA_W);

    generate
        if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
            $error("uart_tx_fifo: DATA_W must be 5..9");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
        end
    endgenerate

    tx_state_t         r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [1:0]        r_stop_cnt;
    logic              r_par_bit;
    logic              r_ser;
    logic              r_busy;
    logic              r_overflow;

    logic [DATA_W-1:0] w_rd_data;
    logic              w_fifo_empty;
    logic              w_last_stop;
    logic              w_pop;

    uart_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_ff1 (rst_ff1),
        .wr_en   (wr_if.wr_en),
        .wr_data (wr_if.wr_data),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (wr_if.full),
        .empty   (w_fifo_empty),
        .level   (wr_if.level)
    );

    assign wr_if.empty    = w_fifo_empty;
    assign wr_if.overflow = r_overflow;
    assign ser_out        = r_ser;
    assign tx_busy        = r_busy;

    // In STOP, the first tick opens stop period 1; the tick after the
    // STOP_BITS-th opening closes the frame.
    assign w_last_stop = (r_state == STOP) && (r_stop_cnt == 2'(STOP_BITS));

    // A word is fetched only when a new frame begins: from IDLE, or
    // chained directly at the end of the last stop period.
    assign w_pop = baud_en & ~w_fifo_empty & ((r_state == IDLE) | w_last_stop);

    always_ff @(posedge clk or posedge rst_ff1) begin
        if (rst_ff1) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_par_bit  <= 1'b0;
            r_ser      <= 1'b1;
            r_busy     <= 1'b0;
        end else if (baud_en) begin
            if (w_pop) begin
                // Load the head word and put the start bit on the line.
                r_shift    <= w_rd_data;
                r_par_bit  <= calc_parity(PARITY, 9'(w_rd_data));
                r_ser      <= 1'b0;
                r_busy     <= 1'b1;
                r_bit_cnt  <= '0;
                r_state    <= DATA;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_ser <= 1'b1;
                    end
                    DATA: begin
                        r_ser   <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                            r_bit_cnt  <= '0;
                            r_stop_cnt <= '0;
                            r_state    <= (PARITY != PAR_NONE) ? PAR : STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    PAR: begin
                        r_ser      <= r_par_bit;
                        r_stop_cnt <= '0;
                        r_state    <= STOP;
                    end
                    STOP: begin
                        r_ser <= 1'b1;
                        if (w_last_stop) begin
                            // Nothing queued: frame ends, line stays idle.
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_ser   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Sticky drop flag; a drop in the same clk as a clear keeps it set.
    always_ff @(posedge clk or posedge rst_ff1) begin
        if (rst_ff1) begin
            r_overflow <= 1'b0;
        end else if (wr_if.wr_en && wr_if.full) begin
            r_overflow <= 1'b1;
        end else if (wr_if.ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter with an input FIFO. It is the next generation of the single-byte transmit path and its din_rdy pulse-capture front end.
- Accepts words from a parallel writer and serialises them LSB-first onto ser_out. Frame format: start bit, DATA_W data bits, optional parity, 1 or 2 stop bits.
- Bit timing comes from an external one-cycle baud tick. The FIFO gives back-to-back frames with no idle gap and reports overflow instead of losing data silently.

Parameters:
- DATA_W, 8, data bits per frame; legal 5..9.
- FIFO_DEPTH, 8, FIFO entries; power of two, >= 2.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_ff1  in  1  asynchronous, active-high reset.
- baud_en  in  1  one-clk tick marking each bit-period boundary.
- wr_en  in  1  write strobe; one word per clk.
- wr_data  in  DATA_W  word to transmit.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- ovf_clr  in  1  clears overflow.
- overflow  out  1  sticky: a write was dropped.
- ser_out  out  1  serial line; idle high.
- tx_busy  out  1  a frame is on the line.

Behaviour:
- Reset (async, rst_ff1=1):
  - ser_out=1, tx_busy=0, full=0, empty=1, level=0, overflow=0.
  - FSM returns to IDLE; FIFO pointers cleared.
  - Reset mid-frame aborts the frame. ser_out goes high asynchronously and no partial frame is resumed.
- FIFO write: accepted when wr_en=1 and full=0 (registered value) in the same clk. A pop in that clk does not free space for that write.
  - wr_en=1 with full=1: word dropped, overflow set from the next clk.
  - overflow set and ovf_clr in the same clk: set wins.
- level: +1 on accepted write, -1 on pop, unchanged when both occur. full = (level==FIFO_DEPTH); empty = (level==0).
- The FSM advances only in clks with baud_en=1; it holds in all other clks.
- IDLE: ser_out=1. On baud_en with empty=0:
  - pop head into shift register, compute parity, drive ser_out=0 (start) from the next clk;
  - tx_busy=1; go to DATA with bit_cnt=0.
- DATA: each baud_en drives ser_out=shift[0], shifts right, increments bit_cnt. After DATA_W ticks:
  - if PARITY!=0, go to PAR;
  - otherwise go to STOP.
- PAR: next baud_en drives the parity bit, then go to STOP.
  - odd: bit = ~^data;
  - even: bit = ^data.
- STOP: each baud_en drives ser_out=1 and counts stop ticks. On the baud_en that ends the last stop period:
  - if empty=0, pop and drive the start bit in that same transition (no idle gap);
  - otherwise go to IDLE with tx_busy=0.
- Frame length: 1 + DATA_W + (PARITY!=0) + STOP_BITS baud periods.
- Latency: start bit appears 1 clk after the first baud_en that sees a non-empty FIFO.
- A word written in the same clk as an IDLE baud_en is not sent until the next baud_en (registered empty).
- wr_data is ignored while wr_en=0. Bits of wr_data above DATA_W do not exist.

Decomposition:
- Shared package uart_pkg holds:
  - parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - FSM state encoding IDLE/DATA/PAR/STOP;
  - a function computing parity for a given mode and data.
- One sub-module: uart_sync_fifo (parameters DATA_W, FIFO_DEPTH; ports wr_en, wr_data, rd_en, rd_data, full, empty, level; reset rst_ff1). It is reused by the future receive path.
- FSM, shifter and overflow flag stay in uart_tx_fifo.

Test Plan:
- Basic frame. DATA_W=8, PARITY=0, STOP_BITS=1, baud_en every 16 clks; write 0xA5 -> ser_out per period is 0 | 1,0,1,0,0,1,0,1 | 1, then idle high; tx_busy high for exactly 10 periods.
- Parity. PARITY=2, write 0x07 -> parity bit 1; PARITY=1, write 0x07 -> parity bit 0; frame is 11 periods.
- Overflow. FIFO_DEPTH=8, baud_en held 0, 9 writes -> full=1 and level=8 after the 8th; 9th dropped; overflow=1. Pulse ovf_clr -> overflow=0 and level still 8.
- Back-to-back. Write 0x00 then 0xFF -> 20 consecutive baud periods. The start bit of 0xFF immediately follows the stop bit of 0x00; tx_busy never drops between frames.
- Two stop bits. STOP_BITS=2, DATA_W=7, write 0x7F -> 0 | 1x7 | 1,1; the next frame starts no earlier than period 11.
- Reset mid-frame. Assert rst_ff1 during data bit 3 of 0x55 with 3 words queued -> ser_out=1 immediately, level=0, tx_busy=0. After release, no further bits until a new write.
